// File: rtl/axi4_burst_addr_gen.sv
// AXI4 address-channel burst expander: turns one AR/AW command into one address per beat,
// flagging illegal bursts with SLVERR while still emitting the full beat count.
module axi4_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_SIZE   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic [1:0]            beat_resp
);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] lower_q, lower_d;
  logic [ADDR_WIDTH-1:0] wrap_end_q, wrap_end_d;

  // Command-side decode, only meaningful on the acceptance cycle.
  logic [ADDR_WIDTH-1:0] cmd_bytes, cmd_mask, cmd_aligned, cmd_total, cmd_lower, cmd_end;
  logic                  wrap_len_ok, size_bad, page_bad, unaligned, cmd_err;

  always_comb begin
    cmd_bytes   = ADDR_WIDTH'(1) << cmd_size;
    cmd_mask    = cmd_bytes - ADDR_WIDTH'(1);
    cmd_aligned = cmd_addr & ~cmd_mask;
    cmd_total   = ADDR_WIDTH'({1'b0, cmd_len} + 9'd1) << cmd_size;
    cmd_lower   = cmd_addr & ~(cmd_total - ADDR_WIDTH'(1));
    cmd_end     = cmd_aligned + (ADDR_WIDTH'(cmd_len) << cmd_size);
    wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) ||
                  (cmd_len == 8'd15);
    size_bad    = 32'(cmd_size) > MAX_SIZE;
    unaligned   = |(cmd_addr & cmd_mask);
    // 4 KB page of the last INCR beat must match the page of the start address.
    page_bad    = cmd_end[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12];
    cmd_err     = (cmd_burst == BurstRsvd) || size_bad ||
                  ((cmd_burst == BurstWrap) && (!wrap_len_ok || unaligned)) ||
                  ((cmd_burst == BurstIncr) && page_bad);
  end

  // Beat-side address stepping.
  logic [ADDR_WIDTH-1:0] cur_bytes, cur_mask, incr_next, wrap_next, next_addr;

  always_comb begin
    cur_bytes = ADDR_WIDTH'(1) << size_q;
    cur_mask  = cur_bytes - ADDR_WIDTH'(1);
    incr_next = (addr_q & ~cur_mask) + cur_bytes;
    wrap_next = addr_q + cur_bytes;
    if (wrap_next == wrap_end_q) begin
      wrap_next = lower_q;
    end
    next_addr = addr_q;
    if (!err_q) begin
      unique case (burst_q)
        BurstIncr: next_addr = incr_next;
        BurstWrap: next_addr = wrap_next;
        default:   next_addr = addr_q;
      endcase
    end
  end

  logic beat_fire, cmd_fire;

  always_comb begin
    beat_valid = (state_q == StBurst);
    beat_last  = beat_valid && (idx_q == len_q);
    beat_fire  = beat_valid && beat_ready;
    cmd_ready  = (state_q == StIdle) || (beat_fire && beat_last);
    cmd_fire   = cmd_valid && cmd_ready;
    beat_id    = id_q;
    beat_addr  = addr_q;
    beat_idx   = idx_q;
    beat_resp  = err_q ? RespSlverr : RespOkay;
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    lower_d    = lower_q;
    wrap_end_d = wrap_end_q;
    if (cmd_fire) begin
      state_d    = StBurst;
      id_d       = cmd_id;
      addr_d     = cmd_addr;
      idx_d      = 8'd0;
      len_d      = cmd_len;
      size_d     = cmd_size;
      burst_d    = cmd_burst;
      err_d      = cmd_err;
      lower_d    = cmd_lower;
      wrap_end_d = cmd_lower + cmd_total;
    end else if (beat_fire) begin
      if (beat_last) begin
        state_d = StIdle;
      end else begin
        idx_d  = idx_q + 8'd1;
        addr_d = next_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= BurstFixed;
      err_q      <= 1'b0;
      lower_q    <= '0;
      wrap_end_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      lower_q    <= lower_d;
      wrap_end_q <= wrap_end_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Scoreboard bench for axi4_burst_addr_gen: directed cases then randomized commands with
// random backpressure, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_axi4_burst_addr_gen;

  localparam time PERIOD = 10;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid, beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [1:0]  beat_resp;

  axi4_burst_addr_gen #(
    .ADDR_WIDTH(32),
    .ID_WIDTH  (4),
    .MAX_SIZE  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_id   (beat_id),
    .beat_addr (beat_addr),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .beat_resp (beat_resp)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  beat_t exp_q[$];
  time   acc_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rand_ready = 0;
  bit    stall_mode = 0;
  int    stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: expected beats straight from the burst address/error rules.
  function automatic void push_expected(input logic [3:0] id, input logic [31:0] a,
                                        input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
    logic [31:0] bytes, aligned, total, lower, ad;
    logic        err;
    bytes   = 32'd1 << size;
    aligned = a & ~(bytes - 32'd1);
    total   = bytes * (32'(len) + 32'd1);
    lower   = a - (a % total);
    err = (burst == 2'b11) || (size > 3'd3) ||
          ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
          ((burst == 2'b10) && ((a % bytes) != 0)) ||
          ((burst == 2'b01) && (((aligned + 32'(len) * bytes) >> 12) != (a >> 12)));
    for (int n = 0; n <= int'(len); n++) begin
      if (err || burst == 2'b00) ad = a;
      else if (burst == 2'b01) ad = (n == 0) ? a : aligned + 32'(n) * bytes;
      else ad = lower + (((a - lower) + 32'(n) * bytes) % total);
      exp_q.push_back(beat_t'{id, ad, 8'(n), (n == int'(len)), err ? 2'b10 : 2'b00});
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that took the command.
  task automatic send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    bit accepted = 0;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    for (int c = 0; c < 3000 && !accepted; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1;
        if (beat_valid) chk("accept_with_last", beat_last, 1'b1);
        push_expected(id, a, len, size, burst);
        acc_q.push_back($time);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    cmd_id    = $urandom;
    cmd_addr  = $urandom;
    if (!accepted) fail_now("cmd_accept");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !beat_valid) ok = 1;
    end
    if (!ok) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode && beat_valid && beat_idx == 8'd1 && stall_cnt < 3) begin
        beat_ready = 1'b0;
        stall_cnt++;
      end else if (rand_ready) begin
        beat_ready = ($urandom_range(0, 3) != 0);
      end else begin
        beat_ready = 1'b1;
      end
    end
  end

  // Monitor: latency, hold-stability and scoreboard comparisons at mid-cycle.
  beat_t held;
  bit    hold = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        while (acc_q.size() > 0 && acc_q[0] + PERIOD <= $time) begin
          if (acc_q[0] + PERIOD == $time) begin
            chk("first_beat_valid", beat_valid, 1'b1);
            chk("first_beat_idx", beat_idx, 8'd0);
          end
          void'(acc_q.pop_front());
        end
        if (hold) begin
          chk("hold_valid", beat_valid, 1'b1);
          chk("hold_beat", {beat_id, beat_addr, beat_idx, beat_last, beat_resp}, held);
        end
        hold = beat_valid && !beat_ready;
        held = {beat_id, beat_addr, beat_idx, beat_last, beat_resp};
        if (beat_valid && beat_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            chk("beat", {beat_id, beat_addr, beat_idx, beat_last, beat_resp},
                exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit found;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          sel;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0;
    cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_beat_valid", beat_valid, 1'b0);
    chk("rst_beat_id", beat_id, 4'd0);
    chk("rst_beat_addr", beat_addr, 32'd0);
    chk("rst_beat_idx", beat_idx, 8'd0);
    chk("rst_beat_last", beat_last, 1'b0);
    chk("rst_beat_resp", beat_resp, 2'b00);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(4'd1, 32'h1002, 8'd3, 3'd2, 2'b01);
    wait_idle();
    send(4'd2, 32'h1038, 8'd3, 3'd3, 2'b10);
    send(4'd3, 32'h0200, 8'd2, 3'd2, 2'b00);
    wait_idle();
    send(4'd4, 32'h0300, 8'd1, 3'd2, 2'b11);
    send(4'd5, 32'h1000, 8'd2, 3'd2, 2'b10);
    send(4'd6, 32'h0FF8, 8'd1, 3'd3, 2'b01);
    send(4'd7, 32'h0040, 8'd0, 3'd4, 2'b01);
    wait_idle();

    stall_mode = 1; stall_cnt = 0;
    send(4'd8, 32'h2000, 8'd3, 3'd2, 2'b01);
    send(4'd9, 32'h3000, 8'd1, 3'd2, 2'b01);
    wait_idle();
    chk("stall_cycles", 64'(stall_cnt), 64'd3);
    stall_mode = 0;

    send(4'd10, 32'h4000, 8'd7, 3'd2, 2'b01);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (beat_valid && beat_idx == 8'd2) found = 1;
    end
    if (!found) fail_now("reach_beat2");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_beat_valid", beat_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    exp_q.delete();
    acc_q.delete();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    send(4'd11, 32'h5004, 8'd0, 3'd2, 2'b01);
    wait_idle();

    send(4'd12, 32'h0, 8'd255, 3'd0, 2'b01);
    wait_idle();

    rand_ready = 1;
    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      burst = (sel < 2) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      size = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      case ($urandom_range(0, 5))
        0, 1:    len = 8'($urandom_range(0, 3));
        2, 3:    len = 8'((1 << $urandom_range(1, 4)) - 1);
        4:       len = 8'($urandom_range(0, 20));
        default: len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd5;
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 64));
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << size) - 32'd1);
      send(4'($urandom), a, len, size, burst);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
